snake_pixel_gen: RTL and testbench

//  Game-state and pixel-classification stage directly upstream of the RGB colour mapper.

---
 rtl/snake_pixel_gen_if.sv | 29 ++
 rtl/snake_pixel_gen.sv | 256 +++++++++++++++++++++++++
 tb/tb_snake_pixel_gen.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/snake_pixel_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : snake_pixel_gen_if
//  Description : Pixel scan, control and status bundle between the game
//                driver (master) and the snake game/pixel stage (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface snake_pixel_gen_if;
    logic [10:0] x_pos;
    logic [10:0] y_pos;
    logic        move_tick;
    logic [1:0]  dir_req;
    logic        dir_valid;
    logic        restart;
    logic [2:0]  snake;
    logic [7:0]  score;
    logic        game_over;

    modport master (
        output x_pos, y_pos, move_tick, dir_req, dir_valid, restart,
        input  snake, score, game_over
    );

    modport slave (
        input  x_pos, y_pos, move_tick, dir_req, dir_valid, restart,
        output snake, score, game_over
    );
endinterface
`default_nettype wire

// File: rtl/snake_pixel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : snake_pixel_gen
//  Description : Snake game state (body, direction, food, FSM) on a cell
//                grid, advanced once per move_tick, plus a one-cycle pixel
//                classifier producing the code for the colour mapper.
//  Revision    : 1.0  initial release
// ============================================================================
module snake_pixel_gen #(
    parameter int CELL_SHIFT = 4,
    parameter int GRID_W     = 40,
    parameter int GRID_H     = 30,
    parameter int MAX_LEN    = 16,
    parameter int INIT_LEN   = 4
) (
    input  wire logic         clk,
    input  wire logic         rst,
    snake_pixel_gen_if.slave  bus
);

    localparam int COL_W = $clog2(GRID_W);
    localparam int ROW_W = $clog2(GRID_H);
    localparam int LEN_W = $clog2(MAX_LEN + 1);

    localparam logic [1:0] C_DIR_UP    = 2'd0;
    localparam logic [1:0] C_DIR_RIGHT = 2'd1;
    localparam logic [1:0] C_DIR_DOWN  = 2'd2;
    localparam logic [1:0] C_DIR_LEFT  = 2'd3;

    localparam logic [15:0]      C_LFSR_SEED = 16'hACE1;
    localparam logic [COL_W-1:0] C_FOOD_COL  = COL_W'(GRID_W / 4);
    localparam logic [ROW_W-1:0] C_FOOD_ROW  = ROW_W'(GRID_H / 4);
    localparam logic [ROW_W-1:0] C_INIT_ROW  = ROW_W'(GRID_H / 2);
    localparam logic [10:0]      C_X_LIMIT   = 11'(GRID_W << CELL_SHIFT);
    localparam logic [10:0]      C_Y_LIMIT   = 11'(GRID_H << CELL_SHIFT);

    typedef enum logic [1:0] {
        ST_PLAY       = 2'd0,
        ST_PLACE_FOOD = 2'd1,
        ST_OVER       = 2'd2
    } state_t;

    // Initial layout: head at grid centre, body trailing to the left.
    function automatic logic [COL_W-1:0] init_col(input int idx);
        return COL_W'(GRID_W / 2 - idx);
    endfunction

    state_t            state_q,     state_d;
    logic [1:0]        dir_q,       dir_d;
    logic [1:0]        pend_q,      pend_d;
    logic [LEN_W-1:0]  len_q,       len_d;
    logic [COL_W-1:0]  seg_col_q [MAX_LEN];
    logic [COL_W-1:0]  seg_col_d [MAX_LEN];
    logic [ROW_W-1:0]  seg_row_q [MAX_LEN];
    logic [ROW_W-1:0]  seg_row_d [MAX_LEN];
    logic [COL_W-1:0]  food_col_q,  food_col_d;
    logic [ROW_W-1:0]  food_row_q,  food_row_d;
    logic [15:0]       lfsr_q,      lfsr_d;
    logic [7:0]        score_q,     score_d;
    logic              game_over_q, game_over_d;
    logic [2:0]        snake_q,     snake_d;
    logic              tick_pend_q, tick_pend_d;

    logic [COL_W-1:0]  w_next_col;
    logic [ROW_W-1:0]  w_next_row;
    logic              w_next_border;
    logic              w_grow;
    logic [MAX_LEN-1:0] w_self_hit_vec;
    logic [5:0]        w_cand_col;
    logic [4:0]        w_cand_row;
    logic [MAX_LEN-1:0] w_cand_hit_vec;
    logic              w_cand_ok;
    logic [10:0]       w_pix_col;
    logic [10:0]       w_pix_row;
    logic              w_pix_in_grid;
    logic              w_pix_border;
    logic              w_pix_head;
    logic [MAX_LEN-1:0] w_pix_body_vec;
    logic              w_pix_food;

    // Cell the head would enter on a move in the pending direction.
    always_comb begin
        w_next_col = seg_col_q[0];
        w_next_row = seg_row_q[0];
        case (pend_q)
            C_DIR_UP:    w_next_row = seg_row_q[0] - ROW_W'(1);
            C_DIR_RIGHT: w_next_col = seg_col_q[0] + COL_W'(1);
            C_DIR_DOWN:  w_next_row = seg_row_q[0] + ROW_W'(1);
            default:     w_next_col = seg_col_q[0] - COL_W'(1);
        endcase
    end

    assign w_next_border = (w_next_col == '0) || (w_next_col == COL_W'(GRID_W - 1)) ||
                           (w_next_row == '0) || (w_next_row == ROW_W'(GRID_H - 1));
    assign w_grow        = (w_next_col == food_col_q) && (w_next_row == food_row_q);

    assign w_cand_col = lfsr_q[5:0];
    assign w_cand_row = lfsr_q[12:8];

    assign w_pix_col     = bus.x_pos >> CELL_SHIFT;
    assign w_pix_row     = bus.y_pos >> CELL_SHIFT;
    assign w_pix_in_grid = (bus.x_pos < C_X_LIMIT) && (bus.y_pos < C_Y_LIMIT);
    assign w_pix_border  = (w_pix_col == 11'd0) || (w_pix_col == 11'(GRID_W - 1)) ||
                           (w_pix_row == 11'd0) || (w_pix_row == 11'(GRID_H - 1));
    assign w_pix_head    = (w_pix_col == 11'(seg_col_q[0])) && (w_pix_row == 11'(seg_row_q[0]));
    assign w_pix_food    = (w_pix_col == 11'(food_col_q)) && (w_pix_row == 11'(food_row_q));

    // Per-segment matches: the tail cell is vacated by a plain move, so it
    // only counts as a collision when the snake grows on this tick.
    for (genvar i = 0; i < MAX_LEN; i++) begin : g_seg
        logic w_live;
        logic w_not_tail;
        assign w_live     = LEN_W'(i) < len_q;
        assign w_not_tail = LEN_W'(i) < (len_q - LEN_W'(1));

        assign w_self_hit_vec[i] = (w_next_col == seg_col_q[i]) && (w_next_row == seg_row_q[i]) &&
                                   (w_not_tail || (w_grow && w_live));
        assign w_cand_hit_vec[i] = w_live && (w_cand_col == 6'(seg_col_q[i])) &&
                                   (w_cand_row == 5'(seg_row_q[i]));
        assign w_pix_body_vec[i] = (i != 0) && w_live &&
                                   (w_pix_col == 11'(seg_col_q[i])) && (w_pix_row == 11'(seg_row_q[i]));
    end

    assign w_cand_ok = (w_cand_col >= 6'd1) && (w_cand_col <= 6'(GRID_W - 2)) &&
                       (w_cand_row >= 5'd1) && (w_cand_row <= 5'(GRID_H - 2)) &&
                       (w_cand_hit_vec == '0);

    // Game FSM, snake movement, food placement and pixel classification.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        pend_d      = pend_q;
        len_d       = len_q;
        seg_col_d   = seg_col_q;
        seg_row_d   = seg_row_q;
        food_col_d  = food_col_q;
        food_row_d  = food_row_q;
        score_d     = score_q;
        tick_pend_d = tick_pend_q;
        lfsr_d      = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

        case (state_q)
            ST_PLAY: begin
                if (bus.move_tick || tick_pend_q) begin
                    tick_pend_d = 1'b0;
                    dir_d       = pend_q;
                    if (w_next_border || (w_self_hit_vec != '0)) begin
                        state_d = ST_OVER;
                    end else begin
                        for (int i = 1; i < MAX_LEN; i++) begin
                            seg_col_d[i] = seg_col_q[i-1];
                            seg_row_d[i] = seg_row_q[i-1];
                        end
                        seg_col_d[0] = w_next_col;
                        seg_row_d[0] = w_next_row;
                        if (w_grow) begin
                            len_d   = (len_q < LEN_W'(MAX_LEN)) ? len_q + LEN_W'(1) : len_q;
                            score_d = (score_q != 8'hFF) ? score_q + 8'd1 : score_q;
                            state_d = ST_PLACE_FOOD;
                        end
                    end
                end
            end
            ST_PLACE_FOOD: begin
                if (bus.move_tick) begin
                    tick_pend_d = 1'b1;
                end
                if (w_cand_ok) begin
                    food_col_d = COL_W'(w_cand_col);
                    food_row_d = ROW_W'(w_cand_row);
                    state_d    = ST_PLAY;
                end
            end
            ST_OVER: begin
                if (bus.restart) begin
                    state_d     = ST_PLAY;
                    dir_d       = C_DIR_RIGHT;
                    pend_d      = C_DIR_RIGHT;
                    len_d       = LEN_W'(INIT_LEN);
                    food_col_d  = C_FOOD_COL;
                    food_row_d  = C_FOOD_ROW;
                    score_d     = 8'd0;
                    tick_pend_d = 1'b0;
                    for (int i = 0; i < MAX_LEN; i++) begin
                        seg_col_d[i] = init_col(i);
                        seg_row_d[i] = C_INIT_ROW;
                    end
                end
            end
            default: state_d = ST_PLAY;
        endcase

        // Reversal is judged against the direction in force after this
        // cycle, so a request can never steer the head back into the neck.
        if ((state_q != ST_OVER) && bus.dir_valid && (bus.dir_req != (dir_d ^ 2'b10))) begin
            pend_d = bus.dir_req;
        end

        game_over_d = (state_d == ST_OVER);

        if (!w_pix_in_grid) begin
            snake_d = 3'b000;
        end else if (w_pix_border) begin
            snake_d = 3'b100;
        end else if (w_pix_head) begin
            snake_d = 3'b001;
        end else if (w_pix_body_vec != '0) begin
            snake_d = (state_q == ST_OVER) ? 3'b001 : 3'b010;
        end else if (w_pix_food) begin
            snake_d = 3'b011;
        end else begin
            snake_d = 3'b000;
        end
    end

    // State registers with asynchronous reset to the start-of-game layout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_PLAY;
            dir_q       <= C_DIR_RIGHT;
            pend_q      <= C_DIR_RIGHT;
            len_q       <= LEN_W'(INIT_LEN);
            food_col_q  <= C_FOOD_COL;
            food_row_q  <= C_FOOD_ROW;
            lfsr_q      <= C_LFSR_SEED;
            score_q     <= 8'd0;
            game_over_q <= 1'b0;
            snake_q     <= 3'b000;
            tick_pend_q <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_col_q[i] <= init_col(i);
                seg_row_q[i] <= C_INIT_ROW;
            end
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            pend_q      <= pend_d;
            len_q       <= len_d;
            seg_col_q   <= seg_col_d;
            seg_row_q   <= seg_row_d;
            food_col_q  <= food_col_d;
            food_row_q  <= food_row_d;
            lfsr_q      <= lfsr_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
            snake_q     <= snake_d;
            tick_pend_q <= tick_pend_d;
        end
    end

    assign bus.snake     = snake_q;
    assign bus.score     = score_q;
    assign bus.game_over = game_over_q;

endmodule
`default_nettype wire

// File: tb/tb_snake_pixel_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snake_pixel_gen
//  Description : Self-checking bench for snake_pixel_gen: directed game
//                scenarios followed by random play, all compared against a
//                queue-based game model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_snake_pixel_gen;

    logic clk;
    logic rst;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    snake_pixel_gen_if bus ();

    snake_pixel_gen #(
        .CELL_SHIFT (4),
        .GRID_W     (40),
        .GRID_H     (30),
        .MAX_LEN    (16),
        .INIT_LEN   (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Game model: body as a queue of cells, head at index 0.
    int          m_col[$];
    int          m_row[$];
    int          m_dir, m_pend, m_fc, m_fr, m_score;
    bit          m_over, m_place, m_tp;
    logic [15:0] m_lfsr;
    logic [2:0]  m_pix;

    function automatic void model_init();
        m_col.delete();
        m_row.delete();
        for (int i = 0; i < 4; i++) begin
            m_col.push_back(20 - i);
            m_row.push_back(15);
        end
        m_dir = 1; m_pend = 1; m_fc = 10; m_fr = 7; m_score = 0;
        m_over = 1'b0; m_place = 1'b0; m_tp = 1'b0;
    endfunction

    function automatic bit on_snake(int c, int r, int from);
        for (int i = from; i < m_col.size(); i++)
            if (m_col[i] == c && m_row[i] == r) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] classify(int x, int y);
        int c = x / 16;
        int r = y / 16;
        if (x >= 640 || y >= 480) return 3'b000;
        if (c == 0 || c == 39 || r == 0 || r == 29) return 3'b100;
        if (c == m_col[0] && r == m_row[0]) return 3'b001;
        if (on_snake(c, r, 1)) return m_over ? 3'b001 : 3'b010;
        if (c == m_fc && r == m_fr) return 3'b011;
        return 3'b000;
    endfunction

    function automatic void model_edge();
        logic [15:0] lf;
        int nc, nr;
        bit grow, hit;
        m_pix  = classify(int'(bus.x_pos), int'(bus.y_pos));
        lf     = m_lfsr;
        m_lfsr = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
        if (m_over) begin
            if (bus.restart) model_init();
            return;
        end
        if (m_place) begin
            if (bus.move_tick) m_tp = 1'b1;
            nc = int'(lf[5:0]);
            nr = int'(lf[12:8]);
            if (nc >= 1 && nc <= 38 && nr >= 1 && nr <= 28 && !on_snake(nc, nr, 0)) begin
                m_fc = nc; m_fr = nr; m_place = 1'b0;
            end
        end else if (bus.move_tick || m_tp) begin
            m_tp  = 1'b0;
            m_dir = m_pend;
            nc = m_col[0] + ((m_dir == 1) ? 1 : (m_dir == 3) ? -1 : 0);
            nr = m_row[0] + ((m_dir == 2) ? 1 : (m_dir == 0) ? -1 : 0);
            if (nc == 0 || nc == 39 || nr == 0 || nr == 29) begin
                m_over = 1'b1;
            end else begin
                grow = (nc == m_fc && nr == m_fr);
                hit  = 1'b0;
                for (int i = 0; i < m_col.size(); i++)
                    if (m_col[i] == nc && m_row[i] == nr && (i < m_col.size() - 1 || grow)) hit = 1'b1;
                if (hit) begin
                    m_over = 1'b1;
                end else begin
                    m_col.push_front(nc);
                    m_row.push_front(nr);
                    if (!grow || m_col.size() > 16) begin
                        void'(m_col.pop_back());
                        void'(m_row.pop_back());
                    end
                    if (grow) begin
                        if (m_score < 255) m_score++;
                        m_place = 1'b1;
                    end
                end
            end
        end
        if (bus.dir_valid && int'(bus.dir_req) != (m_dir ^ 2)) m_pend = int'(bus.dir_req);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: advance the model alongside the DUT, then compare outputs.
    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_init();
            m_lfsr = 16'hACE1;
            m_pix  = 3'b000;
        end else begin
            model_edge();
        end
        #1;
        chk("pix",   32'(bus.snake),     32'(m_pix));
        chk("score", 32'(bus.score),     32'(m_score));
        chk("over",  32'(bus.game_over), 32'(m_over));
    endtask

    task automatic set_cell(input int c, input int r);
        bus.x_pos = 11'(c * 16 + 8);
        bus.y_pos = 11'(r * 16 + 8);
    endtask

    task automatic probe(input string tag, input int c, input int r, input logic [2:0] exp);
        set_cell(c, r);
        step();
        chk(tag, 32'(bus.snake), 32'(exp));
    endtask

    task automatic settle();
        for (int k = 0; k < 64 && (m_place || m_tp); k++) step();
        chk("place_timeout", 32'({m_place, m_tp}), 32'd0);
    endtask

    task automatic move(input int d);
        bus.dir_valid = 1'b1;
        bus.dir_req   = 2'(d);
        step();
        bus.dir_valid = 1'b0;
        bus.move_tick = 1'b1;
        step();
        bus.move_tick = 1'b0;
        settle();
    endtask

    task automatic pulse_restart();
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
    endtask

    // Head from the reset layout to one cell right of the initial food,
    // then turn left and eat on the returned tick edge.
    task automatic approach_food();
        for (int k = 0; k < 8; k++) move(0);
        for (int k = 0; k < 9; k++) move(3);
        bus.dir_valid = 1'b1;
        bus.dir_req   = 2'd3;
        step();
        bus.dir_valid = 1'b0;
        bus.move_tick = 1'b1;
        step();
        bus.move_tick = 1'b0;
    endtask

    initial begin
        int sel, idx;
        rst = 1'b1;
        bus.x_pos = '0; bus.y_pos = '0; bus.move_tick = 1'b0;
        bus.dir_req = 2'd0; bus.dir_valid = 1'b0; bus.restart = 1'b0;
        model_init();
        m_lfsr = 16'hACE1;
        m_pix  = 3'b000;

        // T1: reset state and basic pixel classes
        step();
        chk("rst_snake", 32'(bus.snake), 32'd0);
        chk("rst_score", 32'(bus.score), 32'd0);
        chk("rst_over",  32'(bus.game_over), 32'd0);
        step();
        rst = 1'b0;
        bus.x_pos = 11'd320; bus.y_pos = 11'd240;
        step();
        chk("t1_head", 32'(bus.snake), 32'd1);
        bus.x_pos = 11'd0; bus.y_pos = 11'd0;
        step();
        chk("t1_border", 32'(bus.snake), 32'd4);
        bus.x_pos = 11'd700; bus.y_pos = 11'd100;
        step();
        chk("t1_offgrid", 32'(bus.snake), 32'd0);
        probe("t1_food", 10, 7, 3'b011);

        // T2: reversal rejected, then a legal turn
        bus.dir_valid = 1'b1; bus.dir_req = 2'd3;
        step();
        bus.dir_valid = 1'b0; bus.move_tick = 1'b1;
        step();
        bus.move_tick = 1'b0;
        probe("t2_head", 21, 15, 3'b001);
        probe("t2_body", 18, 15, 3'b010);
        probe("t2_tail_gone", 17, 15, 3'b000);
        chk("t2_score", 32'(bus.score), 32'd0);
        move(0);
        probe("t2_up_head", 21, 14, 3'b001);
        probe("t2_up_body", 21, 15, 3'b010);

        // T3: eat at (10,7); a tick during food placement moves once
        for (int k = 0; k < 7; k++) move(0);
        for (int k = 0; k < 10; k++) move(3);
        bus.dir_valid = 1'b1; bus.dir_req = 2'd3;
        step();
        bus.dir_valid = 1'b0; bus.move_tick = 1'b1;
        step();
        chk("t3_score", 32'(bus.score), 32'd1);
        step();
        bus.move_tick = 1'b0;
        settle();
        probe("t3_head", 9, 7, 3'b001);
        probe("t3_neck", 10, 7, 3'b010);
        probe("t3_grown_tail", 13, 7, 3'b010);
        if (!m_place) probe("t3_newfood", m_fc, m_fr, 3'b011);

        // T4: run right into the wall
        move(0);
        for (int k = 0; k < 40 && !m_over; k++) move(1);
        chk("t4_over", 32'(bus.game_over), 32'd1);
        probe("t4_head", 38, 6, 3'b001);
        probe("t4_body_dead", 37, 6, 3'b001);
        probe("t4_wall", 39, 6, 3'b100);
        for (int k = 0; k < 3; k++) move(3);
        probe("t4_frozen", 38, 6, 3'b001);

        // T6a: restart restores the reset layout
        pulse_restart();
        chk("t6_over", 32'(bus.game_over), 32'd0);
        chk("t6_score", 32'(bus.score), 32'd0);
        probe("t6_head", 20, 15, 3'b001);
        probe("t6_body", 17, 15, 3'b010);
        probe("t6_food", 10, 7, 3'b011);

        // T5: grow to five segments, then up/left/down into own body
        approach_food();
        settle();
        move(2); move(1); move(1); move(1);
        move(0); move(3); move(2);
        chk("t5_over", 32'(bus.game_over), 32'd1);
        probe("t5_head", 12, 7, 3'b001);

        // T6b: asynchronous reset while placing food
        pulse_restart();
        approach_food();
        chk("t6b_score", 32'(bus.score), 32'd1);
        rst = 1'b1;
        #1;
        chk("t6b_snake", 32'(bus.snake), 32'd0);
        chk("t6b_score0", 32'(bus.score), 32'd0);
        chk("t6b_over", 32'(bus.game_over), 32'd0);
        step();
        rst = 1'b0;

        // Random play
        for (int n = 0; n < 4000; n++) begin
            sel = int'($urandom_range(0, 3));
            if (sel == 0) begin
                bus.x_pos = 11'($urandom_range(0, 799));
                bus.y_pos = 11'($urandom_range(0, 524));
            end else begin
                if (sel == 1) begin
                    set_cell(m_col[0], m_row[0]);
                end else if (sel == 2) begin
                    idx = int'($urandom_range(0, m_col.size() - 1));
                    set_cell(m_col[idx], m_row[idx]);
                end else begin
                    set_cell(m_fc, m_fr);
                end
                bus.x_pos = bus.x_pos - 11'd8 + 11'($urandom_range(0, 15));
            end
            bus.move_tick = ($urandom_range(0, 5) == 0);
            bus.dir_valid = ($urandom_range(0, 2) == 0);
            bus.dir_req   = 2'($urandom_range(0, 3));
            bus.restart   = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
